nios_system_data_master: RTL and testbench
==========================================

// Module: nios_system_data_master
// PURPOSE
//  Avalon-MM master that drives the 8-bit bidirectional data PIO slave: the opposite end of its s1 interface.
//  Turns byte-level send/receive commands from the link logic into PIO register accesses.
//  Manages the direction register (addr 1) and the data register (addr 0), with pin settle time after a turnaround.
//  Sits between the battleship link FSM and the data PIO in the nios_system fabric.
// PARAMETERS
//  SETTLE_CYCLES  4  idle cycles after a direction write before data access; 0 = no wait
//  CNT_W          4  settle counter width; must hold SETTLE_CYCLES
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   asynchronous active-low reset
//  cmd_valid       in   1   command request
//  cmd_ready       out  1   high only in IDLE; command accepted when cmd_valid && cmd_ready
//  cmd_write       in   1   1 = drive cmd_byte onto pins, 0 = sample pins
//  cmd_byte        in   8   byte to send (ignored on read)
//  rsp_valid       out  1   one-cycle pulse: read data on rsp_byte
//  rsp_byte        out  8   sampled pin byte; held until next read completes
//  busy            out  1   high in any state other than IDLE
//  avm_address     out  2   PIO register select: 0 = data, 1 = direction
//  avm_chipselect  out  1   access strobe, one cycle per access
//  avm_write_n     out  1   active-low write strobe
//  avm_writedata   out  32  {24'b0, byte}
//  avm_readdata    in   32  PIO readdata; registered by slave, 1-cycle latency, only [7:0] used
// BEHAVIOUR
//  Reset: cmd_ready=0 for the reset cycle then 1; rsp_valid=0; rsp_byte=0; busy=0; avm_chipselect=0;
//   avm_write_n=1; avm_address=0; avm_writedata=0; dir_cache=8'h00 (matches slave data_dir reset).
//  All outputs are registered. Avalon signals change only on clk rising edge.
//  States: IDLE, DIR_WR, SETTLE, DATA_WR, RD_ADDR, RD_CAP.
//  IDLE: on accept, latch cmd_write and cmd_byte. need_dir = (want != dir_cache); want = FF for write, 00 for read.
//   need_dir -> DIR_WR. Otherwise write -> DATA_WR, read -> RD_ADDR.
//  DIR_WR: one cycle, cs=1, write_n=0, addr=1, wdata=want. dir_cache<=want.
//   Then SETTLE if SETTLE_CYCLES>0, else go directly to DATA_WR or RD_ADDR.
//  SETTLE: counts SETTLE_CYCLES cycles with cs=0, then goes to DATA_WR or RD_ADDR.
//  DATA_WR: one cycle, cs=1, write_n=0, addr=0, wdata={24'b0,byte} -> IDLE. No rsp pulse on writes.
//  RD_ADDR: one cycle, addr=0, cs=1, write_n=1. Slave registers pin value at this edge.
//  RD_CAP: cs=0. Capture avm_readdata[7:0] into rsp_byte, pulse rsp_valid -> IDLE.
//  avm_address holds 0 outside DIR_WR, so the slave readdata always reflects data_in.
//  Latency, accept to strobe: write no turn = 1 cycle.
//  Read, no turnaround: rsp_valid 3 cycles after accept.
//   With turnaround: +1+SETTLE_CYCLES.
//  cmd_valid during busy is ignored, with no queueing. Back-to-back commands accept every IDLE cycle.
//  Reset mid-operation: abort to IDLE, with no partial strobe. dir_cache returns to 00.
//   The slave shares reset_n, so both sides agree.
//  cmd_byte is sampled only at accept; later changes have no effect.
// CONFIGURATION
//  DATA_MASTER_DIR_CACHE_EN defined: direction write skipped when dir_cache already equals want.
//  DATA_MASTER_DIR_CACHE_EN undefined: every command issues DIR_WR (+SETTLE) first.
//   In this build dir_cache is still tracked but ignored for the decision.
// TESTING
//  Reset, then write 8'hA5 -> DIR_WR addr1 wdata FF, then 4 settle cycles.
//   Then DATA_WR addr0 wdata 0x000000A5; busy low after.
//  Second write 8'h3C (CACHE_EN) -> no DIR_WR; a single addr0 write 1 cycle after accept.
//  Read with pins=8'h5A after writes -> DIR_WR 00, settle, RD_ADDR.
//   rsp_valid 1 cycle with rsp_byte=5A.
//  Two reads back-to-back, pins 11 then 22 -> no second DIR_WR (CACHE_EN).
//   rsp_byte 11 then 22; without macro each read has DIR_WR.
//  cmd_valid held high during busy -> exactly one command accepted per IDLE visit.
//   No extra chipselect pulses.
//  Assert reset_n low during SETTLE -> cs=0, write_n=1, busy=0 immediately.
//   Next write again issues DIR_WR FF.

Source files
------------

// File: rtl/nios_system_data_master.sv
// nios_system_data_master: Avalon-MM master driving the 8-bit bidirectional data PIO slave
//
// Turns byte send/receive commands into PIO register accesses:
//   addr 1 = direction register (FF = drive pins, 00 = sample pins), addr 0 = data register.
// After each direction write the master idles SETTLE_CYCLES cycles so the pins settle.
// Optional build macro DATA_MASTER_DIR_CACHE_EN: when defined, the direction write (and
// its settle time) is skipped if the cached direction already matches the command.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_write, cmd_byte   1 = send cmd_byte onto the pins, 0 = sample the pins
//   rsp_valid, rsp_byte   one-cycle pulse with the sampled byte; rsp_byte holds until the next read
//   busy                  high whenever a command is in progress
//   avm_*                 Avalon-MM master signals towards the PIO s1 slave
module nios_system_data_master #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_byte,
    output logic        rsp_valid,
    output logic [7:0]  rsp_byte,
    output logic        busy,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);
    typedef enum logic [2:0] {IDLE, DIR_WR, SETTLE, DATA_WR, RD_ADDR, RD_CAP} state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

    state_t           state, state_nxt;
    logic             wr_q, wr_nxt;
    logic [7:0]       data_q, data_nxt, want_nxt, dir_cache;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept, need_dir;
    logic             cs_nxt, wn_nxt;
    logic [1:0]       addr_nxt;
    logic [31:0]      wd_nxt;

    assign accept = cmd_valid && cmd_ready;

`ifdef DATA_MASTER_DIR_CACHE_EN
    logic unused_bits;
    assign unused_bits = ^avm_readdata[31:8];
`else
    // dir_cache is still maintained so a later build can switch caching on, but it never steers here
    logic unused_bits;
    assign unused_bits = ^{avm_readdata[31:8], dir_cache};
`endif

    always_comb begin
        wr_nxt    = accept ? cmd_write : wr_q;
        data_nxt  = accept ? cmd_byte : data_q;
        want_nxt  = {8{wr_nxt}};
`ifdef DATA_MASTER_DIR_CACHE_EN
        need_dir  = want_nxt != dir_cache;
`else
        need_dir  = 1'b1;
`endif
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:    if (accept) state_nxt = need_dir ? DIR_WR : (cmd_write ? DATA_WR : RD_ADDR);
            DIR_WR: begin
                state_nxt = SETTLE_CYCLES > 0 ? SETTLE : (wr_q ? DATA_WR : RD_ADDR);
                cnt_nxt   = SETTLE_LOAD;
            end
            SETTLE: begin
                state_nxt = cnt == '0 ? (wr_q ? DATA_WR : RD_ADDR) : SETTLE;
                cnt_nxt   = cnt - CNT_W'(1);
            end
            DATA_WR: state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_CAP;
            RD_CAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // bus outputs are registered images of the state being entered
        cs_nxt   = state_nxt inside {DIR_WR, DATA_WR, RD_ADDR};
        wn_nxt   = !(state_nxt inside {DIR_WR, DATA_WR});
        addr_nxt = state_nxt == DIR_WR ? 2'd1 : 2'd0;
        wd_nxt   = state_nxt == DIR_WR ? {24'b0, want_nxt} :
                   state_nxt == DATA_WR ? {24'b0, data_nxt} : 32'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            wr_q           <= 1'b0;
            data_q         <= 8'h00;
            dir_cache      <= 8'h00;
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_byte       <= 8'h00;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 2'd0;
            avm_writedata  <= 32'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            wr_q           <= wr_nxt;
            data_q         <= data_nxt;
            if (state == DIR_WR) dir_cache <= {8{wr_q}};
            cmd_ready      <= state_nxt == IDLE;
            busy           <= state_nxt != IDLE;
            rsp_valid      <= state == RD_CAP;
            // readdata was registered by the slave at the RD_ADDR edge
            if (state == RD_CAP) rsp_byte <= avm_readdata[7:0];
            avm_chipselect <= cs_nxt;
            avm_write_n    <= wn_nxt;
            avm_address    <= addr_nxt;
            avm_writedata  <= wd_nxt;
        end
    end
endmodule

// File: tb/tb_nios_system_data_master.sv
// tb_nios_system_data_master: transaction-level model check of the PIO data master
module tb_nios_system_data_master;
    localparam int S = 4;
    localparam int N = 4096;

    logic        clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [7:0]  cmd_byte = 8'h00;
    logic        cmd_ready, rsp_valid, busy, avm_chipselect, avm_write_n;
    logic [7:0]  rsp_byte;
    logic [1:0]  avm_address;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'b0;
    logic [7:0]  pins = 8'h00;
    logic [23:0] junk = 24'h0;

    int tests = 0, fails = 0, cyc = 0, rst_until = N;
    logic       e_cs[N], e_wn[N], e_busy[N], e_rv[N];
    logic [1:0] e_addr[N];
    logic [7:0] e_wd[N], pin_hist[N];
    logic [7:0] dcache = 8'h00, e_rb = 8'h00;

    nios_system_data_master dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_byte(cmd_byte), .rsp_valid(rsp_valid), .rsp_byte(rsp_byte),
        .busy(busy), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    // PIO slave stand-in: readdata registers the pins every cycle, upper bits are noise
    always @(posedge clk) begin
        pin_hist[cyc] <= pins;
        avm_readdata  <= {junk, pins};
        cyc           <= cyc + 1;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
        end
    endtask

    task automatic clear_from(input int s);
        for (int i = s; i < N; i++) begin
            e_cs[i] = 0; e_wn[i] = 1; e_busy[i] = 0; e_rv[i] = 0; e_addr[i] = 0; e_wd[i] = 0;
        end
    endtask

    task automatic put(input int i, input logic cs, input logic wn, input logic [1:0] ad, input logic [7:0] wd);
        e_cs[i] = cs; e_wn[i] = wn; e_addr[i] = ad; e_wd[i] = wd; e_busy[i] = 1;
    endtask

    // schedule the bus activity of a command accepted at the end of cycle k
    task automatic sched(input int k, input logic w, input logic [7:0] b);
        int a;
        logic [7:0] want;
        logic turn;
        a = k + 1;
        want = w ? 8'hFF : 8'h00;
`ifdef DATA_MASTER_DIR_CACHE_EN
        turn = want != dcache;
`else
        turn = 1'b1;
`endif
        if (turn) begin
            put(a, 1, 0, 1, want);
            for (int i = a + 1; i <= a + S; i++) e_busy[i] = 1;
            dcache = want;
            a += 1 + S;
        end
        if (w) put(a, 1, 0, 0, b);
        else begin
            put(a, 1, 1, 0, 8'h00);
            e_busy[a + 1] = 1;
            e_rv[a + 2] = 1;
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [7:0] b);
        @(negedge clk);
        #2;
        cmd_valid = v; cmd_write = w; cmd_byte = b;
        if (v && cyc > rst_until && !e_busy[cyc]) sched(cyc, w, b);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step(0, 0, 8'h00);
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        rst_until = N;
        clear_from(cyc + 1);
        dcache = 8'h00;
        e_rb = 8'h00;
        #1;
        chk("rst_cs", {31'b0, avm_chipselect}, 0);
        chk("rst_wn", {31'b0, avm_write_n}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        repeat (2) step(0, 0, 8'h00);
        reset_n = 1'b1;
        rst_until = cyc;
    endtask

    // single compare process: every cycle, outputs against the model's schedule
    always @(negedge clk) begin
        int c;
        c = cyc;
        if (e_rv[c] && c >= 2) e_rb = pin_hist[c - 2];
        chk("cs", {31'b0, avm_chipselect}, {31'b0, e_cs[c]});
        chk("write_n", {31'b0, avm_write_n}, {31'b0, e_wn[c]});
        chk("addr", {30'b0, avm_address}, {30'b0, e_addr[c]});
        chk("busy", {31'b0, busy}, {31'b0, e_busy[c]});
        chk("ready", {31'b0, cmd_ready}, {31'b0, c > rst_until && !e_busy[c]});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv[c]});
        chk("rsp_byte", {24'b0, rsp_byte}, {24'b0, e_rb});
        if ((e_cs[c] && !e_wn[c]) || c <= rst_until) chk("wdata", avm_writedata, {24'b0, e_wd[c]});
    end

    initial begin
        int k, lat;
        clear_from(0);
        repeat (3) step(0, 0, 8'h00);
        reset_n = 1'b1;
        rst_until = cyc;
        step(0, 0, 8'h00);
        chk("ready_after_reset", {31'b0, cmd_ready}, 1);

        step(1, 1, 8'hA5); k = cyc;
        step(0, 0, 8'h00);
        chk("wrA5_dir_addr", {30'b0, avm_address}, 1);
        chk("wrA5_dir_wdata", avm_writedata, 32'h000000FF);
        wait_to(k + 6);
        chk("wrA5_data", avm_writedata, 32'h000000A5);
        chk("wrA5_data_cs", {31'b0, avm_chipselect}, 1);
        step(0, 0, 8'h00);
        chk("wrA5_busy_after", {31'b0, busy}, 0);

        step(1, 1, 8'h3C); k = cyc;
        step(1, 0, 8'hEE);
`ifdef DATA_MASTER_DIR_CACHE_EN
        chk("wr3C_addr", {30'b0, avm_address}, 0);
        chk("wr3C_wdata", avm_writedata, 32'h0000003C);
`else
        chk("wr3C_addr", {30'b0, avm_address}, 1);
        chk("wr3C_wdata", avm_writedata, 32'h000000FF);
`endif
        wait_to(k + 12);

        pins = 8'h5A;
        step(1, 0, 8'h00); k = cyc;
        wait_to(k + 8);
        chk("rd5A_valid", {31'b0, rsp_valid}, 1);
        chk("rd5A_byte", {24'b0, rsp_byte}, 32'h5A);
        step(0, 0, 8'h00);
        chk("rd5A_pulse", {31'b0, rsp_valid}, 0);

`ifdef DATA_MASTER_DIR_CACHE_EN
        lat = 3;
`else
        lat = 3 + 1 + S;
`endif
        pins = 8'h11;
        step(1, 0, 8'h00); k = cyc;
        wait_to(k + lat);
        chk("rd11_valid", {31'b0, rsp_valid}, 1);
        chk("rd11_byte", {24'b0, rsp_byte}, 32'h11);
        pins = 8'h22;
        step(1, 0, 8'h00); k = cyc;
        wait_to(k + lat);
        chk("rd22_valid", {31'b0, rsp_valid}, 1);
        chk("rd22_byte", {24'b0, rsp_byte}, 32'h22);

        step(1, 1, 8'h77); k = cyc;
        wait_to(k + 3);
        mid_reset();
        step(0, 0, 8'h00);
        step(1, 1, 8'h99);
        step(0, 0, 8'h00);
        chk("post_rst_dir_addr", {30'b0, avm_address}, 1);
        chk("post_rst_dir_wdata", avm_writedata, 32'h000000FF);
        wait_to(cyc + 10);

        for (int i = 0; i < 1500; i++) begin
            pins = 8'($urandom);
            junk = 24'($urandom);
            if ($urandom_range(0, 299) == 0) mid_reset();
            else step($urandom_range(0, 9) < 7, 1'($urandom), 8'($urandom));
        end
        repeat (20) step(0, 0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
